// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR and fetches one word per controller request
// over a variable-latency req/ack memory port, aborting after TIMEOUT wait cycles.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [3:0]        instruction,
   output logic              ir_valid,
   output logic              fetch_done,
   output logic              fetch_err,
   output logic              busy
);

   localparam int unsigned      CNT_W    = 8;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  tmo_cnt;
   logic              jmp_pend;
   logic [ADDR_W-1:0] jmp_tgt;
   logic              jmp_hit;
   logic [ADDR_W-1:0] jmp_dst;

   // A jump arriving in the same cycle as the ack or abort still redirects this fetch.
   assign jmp_hit     = jmp_pend | pc_load;
   assign jmp_dst     = pc_load ? pc_load_val : jmp_tgt;
   assign instruction = ir[DATA_W-1 -: 4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= ADDR_W'(RESET_PC);
         ir         <= '0;
         ir_valid   <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
         busy       <= 1'b0;
         jmp_pend   <= 1'b0;
         jmp_tgt    <= '0;
         tmo_cnt    <= '0;
      end else begin
         fetch_done <= 1'b0;

         // Jumps during a fetch are parked; the latest one wins.
         if ((state == REQ || state == WAIT) && pc_load) begin
            jmp_pend <= 1'b1;
            jmp_tgt  <= pc_load_val;
         end

         case (state)
            IDLE: begin
               if (pc_load) pc <= pc_load_val;
               if (fetch_start) begin
                  state     <= REQ;
                  mem_req   <= 1'b1;
                  busy      <= 1'b1;
                  fetch_err <= 1'b0;
                  tmo_cnt   <= '0;
                  mem_addr  <= pc_load ? pc_load_val : pc;
               end
            end
            REQ, WAIT: begin
               if (mem_ack) begin
                  ir         <= mem_rdata;
                  ir_valid   <= 1'b1;
                  mem_req    <= 1'b0;
                  busy       <= 1'b0;
                  fetch_done <= 1'b1;
                  state      <= DONE;
                  pc         <= jmp_hit ? jmp_dst : mem_addr + ADDR_W'(1);
                  jmp_pend   <= 1'b0;
               end else if (state == WAIT && tmo_cnt == TMO_LAST) begin
                  fetch_err <= 1'b1;
                  mem_req   <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
                  if (jmp_hit) pc <= jmp_dst;
                  jmp_pend  <= 1'b0;
               end else begin
                  state <= WAIT;
                  if (state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (pc_load) pc <= pc_load_val;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset-mid-fetch sequence and
// randomized fetches checked against a transaction-level model.
module tb_instr_fetch_unit;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 8;
   localparam int          TMO    = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              fetch_start;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_val;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [3:0]        instruction;
   logic              ir_valid;
   logic              fetch_done;
   logic              fetch_err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO), .RESET_PC(0)
   ) dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc(pc), .ir(ir),
      .instruction(instruction), .ir_valid(ir_valid), .fetch_done(fetch_done),
      .fetch_err(fetch_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              set_en;
      logic [ADDR_W-1:0] set_val;
      logic              ld;
      logic [ADDR_W-1:0] ldv;
      int                lat;
      int                jc;
      logic [ADDR_W-1:0] jv;
      int                jc2;
      logic [ADDR_W-1:0] jv2;
      logic [ADDR_W-1:0] ea;
      logic              eok;
      logic [ADDR_W-1:0] epc;
      logic [DATA_W-1:0] eir;
      logic              eirv;
   } vec_t;

   vec_t vecs[11];

   // Memory image: address 0 holds 8'hA5.
   function automatic logic [7:0] mem_word(input logic [12:0] a);
      return 8'(a[7:0] * 8'd37) ^ 8'hA5 ^ {3'b000, a[12:8]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pc"},          32'(pc), 32'd0);
      chk({tag, " ir"},          32'(ir), 32'd0);
      chk({tag, " instruction"}, 32'(instruction), 32'd0);
      chk({tag, " ir_valid"},    32'(ir_valid), 32'd0);
      chk({tag, " mem_req"},     32'(mem_req), 32'd0);
      chk({tag, " mem_addr"},    32'(mem_addr), 32'd0);
      chk({tag, " fetch_done"},  32'(fetch_done), 32'd0);
      chk({tag, " fetch_err"},   32'(fetch_err), 32'd0);
      chk({tag, " busy"},        32'(busy), 32'd0);
   endtask

   task automatic set_pc(input logic [ADDR_W-1:0] v);
      pc_load     = 1'b1;
      pc_load_val = v;
      mem_ack     = 1'($urandom_range(0, 1));
      mem_rdata   = 8'($urandom);
      step();
      pc_load = 1'b0;
      mem_ack = 1'b0;
      chk("idle_load pc", 32'(pc), 32'(v));
      chk("idle_load busy", 32'(busy), 32'd0);
   endtask

   // One fetch: start, memory acks after lat cycles (0 = in REQ), optional jumps at
   // cycles jc/jc2, then one extra cycle with an optional pc load and a stray fetch_start.
   task automatic do_fetch(input logic ld, input logic [ADDR_W-1:0] ldv, input int lat,
                           input int jc, input logic [ADDR_W-1:0] jv,
                           input int jc2, input logic [ADDR_W-1:0] jv2,
                           input logic [ADDR_W-1:0] ea, input logic eok,
                           input logic [ADDR_W-1:0] epc, input logic [DATA_W-1:0] eir,
                           input logic eirv, input logic dld, input logic [ADDR_W-1:0] dlv);
      logic fin;
      fin         = 1'b0;
      fetch_start = 1'b1;
      pc_load     = ld;
      pc_load_val = ldv;
      step();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      for (int j = 0; j <= TMO && !fin; j++) begin
         chk("busy mem_req", 32'(mem_req), 32'd1);
         chk("busy mem_addr", 32'(mem_addr), 32'(ea));
         chk("busy flag", 32'(busy), 32'd1);
         chk("busy pc", 32'(pc), 32'(ea));
         chk("busy fetch_err", 32'(fetch_err), 32'd0);
         mem_ack     = (j == lat);
         mem_rdata   = (j == lat) ? mem_word(mem_addr) : 8'($urandom);
         pc_load     = (j == jc) || (j == jc2);
         pc_load_val = (j == jc2) ? jv2 : jv;
         fin         = (j == lat) || (j == TMO);
         step();
      end
      mem_ack = 1'b0;
      pc_load = 1'b0;
      chk("end fetch_done", 32'(fetch_done), 32'(eok));
      chk("end fetch_err", 32'(fetch_err), 32'(!eok));
      chk("end mem_req", 32'(mem_req), 32'd0);
      chk("end busy", 32'(busy), 32'd0);
      chk("end ir", 32'(ir), 32'(eir));
      chk("end instruction", 32'(instruction), 32'(eir[7:4]));
      chk("end ir_valid", 32'(ir_valid), 32'(eirv));
      chk("end pc", 32'(pc), 32'(epc));
      fetch_start = eok;
      pc_load     = dld;
      pc_load_val = dlv;
      mem_ack     = 1'($urandom_range(0, 1));
      mem_rdata   = 8'($urandom);
      step();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      mem_ack     = 1'b0;
      chk("after fetch_done", 32'(fetch_done), 32'd0);
      chk("after busy", 32'(busy), 32'd0);
      chk("after mem_req", 32'(mem_req), 32'd0);
      chk("after ir", 32'(ir), 32'(eir));
      chk("after pc", 32'(pc), 32'(dld ? dlv : epc));
   endtask

   logic [ADDR_W-1:0] m_pc;
   logic [DATA_W-1:0] m_ir;
   logic              m_irv;

   initial begin
      rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_load_val = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      step();
      step();
      chk_reset("por");
      rst = 1'b0;
      step();
      chk_reset("post_release");

      //          set   set_val    ld    ldv        lat jc  jv         jc2 jv2        ea         eok   epc        eir                    eirv
      vecs[0]  = '{1'b0, 13'h0000, 1'b0, 13'h0000,   2, -1, 13'h0000,  -1, 13'h0000, 13'h0000, 1'b1, 13'h0001, 8'hA5,                 1'b1};
      vecs[1]  = '{1'b0, 13'h0000, 1'b0, 13'h0000,   0, -1, 13'h0000,  -1, 13'h0000, 13'h0001, 1'b1, 13'h0002, mem_word(13'h0001),    1'b1};
      vecs[2]  = '{1'b1, 13'h1FFF, 1'b0, 13'h0000,   1, -1, 13'h0000,  -1, 13'h0000, 13'h1FFF, 1'b1, 13'h0000, mem_word(13'h1FFF),    1'b1};
      vecs[3]  = '{1'b1, 13'h0005, 1'b0, 13'h0000,   4,  1, 13'h0100,  -1, 13'h0000, 13'h0005, 1'b1, 13'h0100, mem_word(13'h0005),    1'b1};
      vecs[4]  = '{1'b1, 13'h0222, 1'b0, 13'h0000,  99, -1, 13'h0000,  -1, 13'h0000, 13'h0222, 1'b0, 13'h0222, mem_word(13'h0005),    1'b1};
      vecs[5]  = '{1'b0, 13'h0000, 1'b0, 13'h0000,  15, -1, 13'h0000,  -1, 13'h0000, 13'h0222, 1'b1, 13'h0223, mem_word(13'h0222),    1'b1};
      vecs[6]  = '{1'b0, 13'h0000, 1'b1, 13'h0AB0,   3, -1, 13'h0000,  -1, 13'h0000, 13'h0AB0, 1'b1, 13'h0AB1, mem_word(13'h0AB0),    1'b1};
      vecs[7]  = '{1'b0, 13'h0000, 1'b0, 13'h0000,  99,  5, 13'h0333,  -1, 13'h0000, 13'h0AB1, 1'b0, 13'h0333, mem_word(13'h0AB0),    1'b1};
      vecs[8]  = '{1'b0, 13'h0000, 1'b0, 13'h0000,   0,  0, 13'h1234,  -1, 13'h0000, 13'h0333, 1'b1, 13'h1234, mem_word(13'h0333),    1'b1};
      vecs[9]  = '{1'b0, 13'h0000, 1'b0, 13'h0000,   3,  1, 13'h0055,   2, 13'h0777, 13'h1234, 1'b1, 13'h0777, mem_word(13'h1234),    1'b1};
      vecs[10] = '{1'b1, 13'h0010, 1'b0, 13'h0000,  16, -1, 13'h0000,  -1, 13'h0000, 13'h0010, 1'b0, 13'h0010, mem_word(13'h1234),    1'b1};

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].set_en) set_pc(vecs[i].set_val);
         do_fetch(vecs[i].ld, vecs[i].ldv, vecs[i].lat, vecs[i].jc, vecs[i].jv,
                  vecs[i].jc2, vecs[i].jv2, vecs[i].ea, vecs[i].eok, vecs[i].epc,
                  vecs[i].eir, vecs[i].eirv, 1'b0, 13'h0000);
      end

      // Reset asserted mid-wait, then an ack while held and after release.
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      step();
      step();
      chk("pre_reset busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #2;
      chk_reset("async_rst");
      mem_ack   = 1'b1;
      mem_rdata = 8'h3C;
      step();
      chk_reset("rst_held_ack");
      rst = 1'b0;
      step();
      chk_reset("rst_released_ack");
      mem_ack = 1'b0;

      m_pc  = '0;
      m_ir  = '0;
      m_irv = 1'b0;
      for (int n = 0; n < 60; n++) begin
         logic              ld, dld, ok, hit;
         logic [ADDR_W-1:0] ldv, dlv, jv, jv2, ea, epc, tgt, sv;
         int                lat, jc, jc2, fin, r;
         if ($urandom_range(0, 1) == 1) begin
            sv = 13'($urandom);
            set_pc(sv);
            m_pc = sv;
         end
         ld  = ($urandom_range(0, 3) == 0);
         ldv = 13'($urandom);
         jv  = 13'($urandom);
         jv2 = 13'($urandom);
         r   = int'($urandom_range(0, 99));
         lat = (r < 70) ? int'($urandom_range(0, 5)) :
               (r < 85) ? int'($urandom_range(6, 15)) : int'($urandom_range(16, 20));
         ok  = (lat <= TMO);
         fin = ok ? lat : TMO;
         jc  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32'(fin))) : -1;
         jc2 = (jc >= 0 && $urandom_range(0, 1) == 1) ? jc + 1 + int'($urandom_range(0, 2)) : -1;
         ea  = ld ? ldv : m_pc;
         hit = 1'b0;
         tgt = '0;
         if (jc >= 0 && jc <= fin) begin hit = 1'b1; tgt = jv; end
         if (jc2 >= 0 && jc2 <= fin) begin hit = 1'b1; tgt = jv2; end
         if (ok) begin
            epc   = hit ? tgt : ea + 13'd1;
            m_ir  = mem_word(ea);
            m_irv = 1'b1;
         end else begin
            epc = hit ? tgt : ea;
         end
         dld = ($urandom_range(0, 3) == 0);
         dlv = 13'($urandom);
         do_fetch(ld, ldv, lat, jc, jv, jc2, jv2, ea, ok, epc, m_ir, m_irv, dld, dlv);
         m_pc = dld ? dlv : epc;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
